// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: load/store size encodings,
// the access FSM state type and lane-count helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int LANES_RV32 = 4;
  localparam int LANES_RV64 = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_GNT   = 2'd1,
    ST_WAIT_RDATA = 2'd2
  } mem_state_e;

  function automatic int lanes(input int xlen);
    return (xlen == 64) ? LANES_RV64 : LANES_RV32;
  endfunction

  // log2 of the access size in bytes; a doubleword on a 32-bit datapath
  // degrades to a word so the lane logic never exceeds the bus width
  function automatic logic [1:0] size_log2(input logic [2:0] f3, input int xlen);
    logic [1:0] s;
    case (f3)
      F3_B, F3_BU: s = 2'd0;
      F3_H, F3_HU: s = 2'd1;
      F3_W, F3_WU: s = 2'd2;
      F3_D:        s = (xlen == 64) ? 2'd3 : 2'd2;
      default:     s = 2'd2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: store byte enables and
// replicated write data, plus load lane extraction and sign/zero extension.
module mem_lane_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                   funct3,
  input  logic [$clog2(XLEN/8)-1:0]    offset,
  input  logic [XLEN-1:0]              sdata,
  input  logic [XLEN-1:0]              rdata,
  output logic [XLEN/8-1:0]            be,
  output logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              ldata
);

  localparam int NB = XLEN / 8;

  logic [1:0]      szl;
  logic [NB-1:0]   be_base;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  assign szl = size_log2(funct3, XLEN);

  // store side: size mask moved to the offset, low bytes copied to every lane
  always_comb begin
    be_base = '0;
    wdata   = sdata;
    case (szl)
      2'd0: begin be_base[0]   = 1'b1; wdata = {NB{sdata[7:0]}};         end
      2'd1: begin be_base[1:0] = '1;   wdata = {(NB/2){sdata[15:0]}};    end
      2'd2: begin be_base[3:0] = '1;   wdata = {(NB/4){sdata[31:0]}};    end
      default: begin be_base = '1;     wdata = sdata;                    end
    endcase
    be = be_base << offset;
  end

  // load side: bring the addressed lane to bit 0, then extend
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    mask    = '0;
    case (szl)
      2'd0: begin mask[7:0]  = '1; sign = shifted[7];      end
      2'd1: begin mask[15:0] = '1; sign = shifted[15];     end
      2'd2: begin mask[31:0] = '1; sign = shifted[31];     end
      default: begin mask    = '1; sign = shifted[XLEN-1]; end
    endcase
    ldata = (shifted & mask) | ({XLEN{sign & ~funct3[2]}} & ~mask);
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues load/store requests on a req/gnt/rvalid bus,
// stalls upstream until the access completes and fills the MEM/WB register.
// Optional build macro MEM_STAGE_MISALIGN_TRAP_EN: misaligned accesses are
// reported on MemWb_Misalign instead of being silently aligned down.
//
// state         | meaning
// ST_IDLE       | accepting a new op; a memory op requests in this cycle
// ST_WAIT_GNT   | request outstanding, bus outputs frozen until mem_gnt
// ST_WAIT_RDATA | load granted, waiting for mem_rvalid
module mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              ExMem_MemRead,
  input  logic              ExMem_MemWrite,
  input  logic [2:0]        ExMem_Funct3,
  input  logic [XLEN-1:0]   ExMem_AluResult,
  input  logic [XLEN-1:0]   ExMem_AluB_Pc4,
  input  logic              ExMem_MemToReg,
  input  logic              ExMem_RegWrite,
  input  logic [4:0]        ExMem_RegRd,
  input  logic              Flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_stall,
  output logic              MemWb_MemToReg,
  output logic              MemWb_RegWrite,
  output logic [4:0]        MemWb_RegRd,
  output logic [XLEN-1:0]   MemWb_AluB_Pc4,
  output logic [XLEN-1:0]   MemWb_MemRData,
  output logic              MemWb_Misalign
);

  localparam int OFFW = $clog2(XLEN / 8);

  mem_state_e state;

  // op captured at issue so the bus stays stable even if upstream is flushed
  logic            q_we, q_kill, q_mtr, q_rw;
  logic [2:0]      q_f3;
  logic [AW-1:0]   q_addr;
  logic [OFFW-1:0] q_off;
  logic [XLEN-1:0] q_b;
  logic [4:0]      q_rd;

  logic            ex_op, idle, issue, misal, done, kill_now, is_load_now;
  logic [1:0]      szl;
  logic [OFFW-1:0] raw_off, sz_m1, ex_off, sel_off;
  logic [2:0]      sel_f3;
  logic [XLEN-1:0] sel_b, ldata, wdata;
  logic [XLEN/8-1:0] be;
  logic [AW-1:0]   ex_addr;

  assign ex_op   = ExMem_MemRead | ExMem_MemWrite;
  assign idle    = (state == ST_IDLE);
  assign szl     = size_log2(ExMem_Funct3, XLEN);
  assign raw_off = ExMem_AluResult[OFFW-1:0];
  assign sz_m1   = OFFW'((1 << szl) - 1);
  assign ex_addr = {ExMem_AluResult[AW-1:OFFW], {OFFW{1'b0}}};

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misal  = ex_op & ((raw_off & sz_m1) != '0);
  assign ex_off = raw_off;
`else
  assign misal  = 1'b0;
  assign ex_off = raw_off & ~sz_m1;
`endif

  assign issue = idle & ex_op & ~Flush & ~misal;

  assign sel_f3  = idle ? ExMem_Funct3   : q_f3;
  assign sel_off = idle ? ex_off         : q_off;
  assign sel_b   = idle ? ExMem_AluB_Pc4 : q_b;

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .funct3 (sel_f3),
    .offset (sel_off),
    .sdata  (sel_b),
    .rdata  (mem_rdata),
    .be     (be),
    .wdata  (wdata),
    .ldata  (ldata)
  );

  assign mem_req   = ~rstb & (issue | (state == ST_WAIT_GNT));
  assign mem_we    = mem_req & (idle ? ExMem_MemWrite : q_we);
  assign mem_be    = mem_req ? be : '0;
  assign mem_addr  = idle ? ex_addr : q_addr;
  assign mem_wdata = wdata;

  // completion: store on grant, load on rvalid (which may coincide with grant)
  always_comb begin
    done = 1'b0;
    case (state)
      ST_IDLE:       done = issue & mem_gnt & (ExMem_MemWrite | mem_rvalid);
      ST_WAIT_GNT:   done = mem_gnt & (q_we | mem_rvalid);
      ST_WAIT_RDATA: done = mem_rvalid;
      default:       done = 1'b0;
    endcase
  end

  assign mem_stall   = ~rstb & (issue | ~idle) & ~done;
  assign kill_now    = idle ? 1'b0 : (q_kill | Flush);
  assign is_load_now = idle ? ~ExMem_MemWrite : ~q_we;

  // access FSM and capture of the op being issued
  always_ff @(posedge clk) begin
    if (rstb) begin
      state  <= ST_IDLE;
      q_kill <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            q_we   <= ExMem_MemWrite;
            q_f3   <= ExMem_Funct3;
            q_off  <= ex_off;
            q_addr <= ex_addr;
            q_b    <= ExMem_AluB_Pc4;
            q_rd   <= ExMem_RegRd;
            q_mtr  <= ExMem_MemToReg;
            q_rw   <= ExMem_RegWrite;
            q_kill <= 1'b0;
            if (!mem_gnt)                              state <= ST_WAIT_GNT;
            else if (!ExMem_MemWrite && !mem_rvalid)   state <= ST_WAIT_RDATA;
          end
        end
        ST_WAIT_GNT: begin
          if (Flush) q_kill <= 1'b1;
          if (mem_gnt) state <= (q_we | mem_rvalid) ? ST_IDLE : ST_WAIT_RDATA;
        end
        ST_WAIT_RDATA: begin
          if (Flush) q_kill <= 1'b1;
          if (mem_rvalid) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // MEM/WB register: bubble (RegWrite=0, rest held) unless something retires
  always_ff @(posedge clk) begin
    if (rstb) begin
      MemWb_MemToReg <= 1'b0;
      MemWb_RegWrite <= 1'b0;
      MemWb_RegRd    <= '0;
      MemWb_AluB_Pc4 <= '0;
      MemWb_MemRData <= '0;
      MemWb_Misalign <= 1'b0;
    end else begin
      MemWb_RegWrite <= 1'b0;
      if (idle && !Flush && !ex_op) begin
        MemWb_MemToReg <= ExMem_MemToReg;
        MemWb_RegWrite <= ExMem_RegWrite;
        MemWb_RegRd    <= ExMem_RegRd;
        MemWb_AluB_Pc4 <= ExMem_AluB_Pc4;
        MemWb_Misalign <= 1'b0;
      end else if (idle && !Flush && misal) begin
        MemWb_MemToReg <= ExMem_MemToReg;
        MemWb_RegRd    <= ExMem_RegRd;
        MemWb_AluB_Pc4 <= ExMem_AluB_Pc4;
        MemWb_Misalign <= 1'b1;
      end else if (done && !kill_now) begin
        MemWb_MemToReg <= idle ? ExMem_MemToReg : q_mtr;
        MemWb_RegWrite <= idle ? ExMem_RegWrite : q_rw;
        MemWb_RegRd    <= idle ? ExMem_RegRd    : q_rd;
        MemWb_AluB_Pc4 <= sel_b;
        MemWb_Misalign <= 1'b0;
        if (is_load_now) MemWb_MemRData <= ldata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage (XLEN=32): the driver pushes expected bus
// transactions and writebacks, negedge monitors pop and compare them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg, ExMem_RegWrite, Flush;
  logic [2:0]  ExMem_Funct3;
  logic [31:0] ExMem_AluResult, ExMem_AluB_Pc4;
  logic [4:0]  ExMem_RegRd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, mem_stall;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        MemWb_MemToReg, MemWb_RegWrite, MemWb_Misalign;
  logic [4:0]  MemWb_RegRd;
  logic [31:0] MemWb_AluB_Pc4, MemWb_MemRData;

  int vectors = 0;
  int errors  = 0;

  typedef struct { logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; logic we; } bus_t;
  typedef struct { logic [4:0] rd; logic mtr; logic [31:0] b; logic [31:0] data; logic ld; } wb_t;
  bus_t bus_q[$];
  wb_t  wb_q[$];
  bus_t bus_item;
  wb_t  wb_item;

  mem_stage #(.XLEN(32), .AW(32)) dut (
    .clk(clk), .rstb(rstb),
    .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_Funct3(ExMem_Funct3), .ExMem_AluResult(ExMem_AluResult),
    .ExMem_AluB_Pc4(ExMem_AluB_Pc4), .ExMem_MemToReg(ExMem_MemToReg),
    .ExMem_RegWrite(ExMem_RegWrite), .ExMem_RegRd(ExMem_RegRd), .Flush(Flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .MemWb_MemToReg(MemWb_MemToReg), .MemWb_RegWrite(MemWb_RegWrite),
    .MemWb_RegRd(MemWb_RegRd), .MemWb_AluB_Pc4(MemWb_AluB_Pc4),
    .MemWb_MemRData(MemWb_MemRData), .MemWb_Misalign(MemWb_Misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // bus monitor: every accepted request must match the next expected access
  always @(negedge clk) begin
    if (!rstb && mem_req && mem_gnt) begin
      if (bus_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL bus_unexpected: got addr %h we %b expected no access", mem_addr, mem_we);
      end else begin
        bus_item = bus_q.pop_front();
        chk("bus_addr", mem_addr, bus_item.addr);
        chk("bus_we", {31'b0, mem_we}, {31'b0, bus_item.we});
        chk("bus_be", {28'b0, mem_be}, {28'b0, bus_item.be});
        if (bus_item.we) chk("bus_wdata", mem_wdata, bus_item.wdata);
      end
    end
  end

  // writeback monitor: every retired register write must match the next one expected
  always @(negedge clk) begin
    if (!rstb && MemWb_RegWrite) begin
      if (wb_q.size() == 0) begin
        vectors++; errors++;
        $display("FAIL wb_unexpected: got rd %0d expected no writeback", MemWb_RegRd);
      end else begin
        wb_item = wb_q.pop_front();
        chk("wb_rd", {27'b0, MemWb_RegRd}, {27'b0, wb_item.rd});
        chk("wb_mtr", {31'b0, MemWb_MemToReg}, {31'b0, wb_item.mtr});
        chk("wb_alub", MemWb_AluB_Pc4, wb_item.b);
        chk("wb_misalign", {31'b0, MemWb_Misalign}, 32'd0);
        if (wb_item.ld) chk("wb_rdata", MemWb_MemRData, wb_item.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // kind: 0 = ALU op, 1 = load, 2 = store
  task automatic run_op(input int kind, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] rdat,
                        input int gdly, input int rdly, input logic fl_idle, input logic fl_wait);
    int sz, off, fin, nstall;
    logic mis, nobus, killed;
    logic [31:0] v, ev;
    bus_t bx;
    wb_t  wx;
    sz  = 1 << f3[1:0];
    off = addr[1:0];
    mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    mis = (kind != 0) && (off % sz != 0);
`else
    off = off - (off % sz);
`endif
    nobus  = (kind == 0) || fl_idle || mis;
    fin    = nobus ? 0 : ((kind == 1) ? gdly + rdly : gdly);
    killed = fl_idle || (fl_wait && fin > 0);

    ExMem_MemRead   = (kind == 1);
    ExMem_MemWrite  = (kind == 2);
    ExMem_Funct3    = f3;
    ExMem_AluResult = addr;
    ExMem_AluB_Pc4  = b;
    ExMem_MemToReg  = (kind == 1);
    ExMem_RegWrite  = (kind != 2);
    ExMem_RegRd     = rd;

    if (!nobus) begin
      bx.addr = {addr[31:2], 2'b00};
      bx.be = 4'((1 << sz) - 1) << off;
      bx.we = (kind == 2);
      case (sz)
        1:       bx.wdata = {4{b[7:0]}};
        2:       bx.wdata = {2{b[15:0]}};
        default: bx.wdata = b;
      endcase
      bus_q.push_back(bx);
    end

    if (kind != 2 && !killed && !mis) begin
      v = rdat >> (8 * off);
      case (sz)
        1:       ev = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
        2:       ev = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
        default: ev = v;
      endcase
      wx.rd = rd; wx.mtr = (kind == 1); wx.b = b; wx.data = ev; wx.ld = (kind == 1);
      wb_q.push_back(wx);
    end

    nstall = 0;
    for (int c = 0; c <= fin; c++) begin
      Flush      = fl_idle || (fl_wait && c > 0);
      mem_gnt    = nobus ? 1'($urandom_range(1)) : (c == gdly);
      mem_rvalid = !nobus && (kind == 1) && (c == gdly + rdly);
      mem_rdata  = mem_rvalid ? rdat : $urandom;
      @(negedge clk);
      if (mem_stall) nstall++;
      if (nobus) chk("req_suppressed", {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    chk("stall_cycles", nstall, fin);
    if (mis) begin
      chk("trap_misalign", {31'b0, MemWb_Misalign}, 32'd1);
      chk("trap_regwrite", {31'b0, MemWb_RegWrite}, 32'd0);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; Flush = 1'b0;
    ExMem_MemRead = 1'b0; ExMem_MemWrite = 1'b0; ExMem_RegWrite = 1'b0;
  endtask

  initial begin
    int kind, gd, rdl;
    logic [2:0] f3;
    rstb = 1'b1;
    ExMem_MemRead = 0; ExMem_MemWrite = 0; ExMem_Funct3 = 0; ExMem_AluResult = 0;
    ExMem_AluB_Pc4 = 0; ExMem_MemToReg = 0; ExMem_RegWrite = 0; ExMem_RegRd = 0;
    Flush = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_wb", {MemWb_MemToReg, MemWb_RegWrite, MemWb_Misalign, MemWb_RegRd}, 32'd0);
    chk("rst_wb_data", MemWb_AluB_Pc4 | MemWb_MemRData, 32'd0);
    rstb = 1'b0;
    @(posedge clk); #1;

    // SB 0x103 <- 0xAB, granted at once
    run_op(2, 3'b000, 32'h103, 32'h0000_00AB, 5'd0, 32'h0, 0, 0, 0, 0);
    // LB 0x102, grant after 2 cycles, rvalid one later
    run_op(1, 3'b000, 32'h102, 32'h1111_2222, 5'd5, 32'h0080_FF00, 2, 1, 0, 0);
    chk("lb_value", MemWb_MemRData, 32'hFFFF_FF80);
    // LHU 0x102 zero-wait
    run_op(1, 3'b101, 32'h102, 32'h3333_4444, 5'd6, 32'h8001_0000, 0, 0, 0, 0);
    chk("lhu_value", MemWb_MemRData, 32'h0000_8001);
    // LW 0x101: trapped, or aligned down to 0x100 in the default build
    run_op(1, 3'b010, 32'h101, 32'h5555_6666, 5'd7, 32'hCAFE_F00D, 1, 1, 0, 0);
    // LW flushed while waiting for rvalid
    run_op(1, 3'b010, 32'h200, 32'h7777_8888, 5'd8, 32'h1234_5678, 0, 2, 0, 1);
    // load flushed before issue
    run_op(1, 3'b010, 32'h300, 32'h9999_AAAA, 5'd9, 32'h0, 0, 0, 1, 0);
    // back-to-back ALU ops
    run_op(0, 3'b000, 32'h0, 32'hDEAD_BEEF, 5'd10, 32'h0, 0, 0, 0, 0);
    run_op(0, 3'b000, 32'h0, 32'h0BAD_F00D, 5'd11, 32'h0, 0, 0, 0, 0);

    // reset while waiting for grant abandons the access
    ExMem_MemRead = 1; ExMem_Funct3 = 3'b010; ExMem_AluResult = 32'h400;
    ExMem_RegWrite = 1; ExMem_RegRd = 5'd12; ExMem_MemToReg = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wait_gnt_stall", {31'b0, mem_stall}, 32'd1);
    rstb = 1'b1; ExMem_MemRead = 0; ExMem_RegWrite = 0;
    @(posedge clk); #1;
    rstb = 1'b0;
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, mem_stall}, 32'd0);
    mem_gnt = 1; mem_rvalid = 1;
    @(posedge clk); #1;
    chk("late_resp_stall", {31'b0, mem_stall}, 32'd0);
    chk("late_resp_wb", {31'b0, MemWb_RegWrite}, 32'd0);
    mem_gnt = 0; mem_rvalid = 0;

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(2);
      if (kind == 2) f3 = 3'($urandom_range(2));
      else begin
        f3 = 3'($urandom_range(5));
        if (f3 > 3'd2) f3 = f3 + 3'd1;
      end
      gd  = $urandom_range(3);
      rdl = $urandom_range(2);
      run_op(kind, f3, $urandom, $urandom, 5'($urandom_range(31)), $urandom, gd, rdl,
             ($urandom_range(15) == 0), ($urandom_range(7) == 0));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("wb_q_drained", wb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (32 or 64).
REQ-002 SHALL have parameter AW, default 32, memory address width (AW <= XLEN).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rstb  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ExMem_MemRead  input  1  load in EX/MEM.
REQ-006 SHALL have port ExMem_MemWrite  input  1  store in EX/MEM.
REQ-007 SHALL have port ExMem_Funct3  input  3  size/sign: 000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU.
REQ-008 SHALL have port ExMem_AluResult  input  XLEN  effective address.
REQ-009 SHALL have port ExMem_AluB_Pc4  input  XLEN  store data or PC+4.
REQ-010 SHALL have port ExMem_MemToReg, ExMem_RegWrite  input  1 each  WB controls.
REQ-011 SHALL have port ExMem_RegRd  input  5  destination register.
REQ-012 SHALL have port Flush  input  1  kill current EX/MEM op.
REQ-013 SHALL have port mem_req  output  1  request valid.
REQ-014 SHALL have port mem_we  output  1  write enable.
REQ-015 SHALL have port mem_be  output  XLEN/8  byte enables.
REQ-016 SHALL have port mem_addr  output  AW  word-aligned address (low log2(XLEN/8) bits zero).
REQ-017 SHALL have port mem_wdata  output  XLEN  lane-shifted store data.
REQ-018 SHALL have port mem_gnt  input  1  request accepted.
REQ-019 SHALL have port mem_rvalid  input  1  read data valid.
REQ-020 SHALL have port mem_rdata  input  XLEN  read data word.
REQ-021 SHALL have port mem_stall  output  1  hold upstream stages.
REQ-022 SHALL have ports MemWb_MemToReg, MemWb_RegWrite  output  1 each; MemWb_RegRd  output  5; MemWb_AluB_Pc4, MemWb_MemRData  output  XLEN; MemWb_Misalign  output  1.

Function
REQ-023 FSM states SHALL be IDLE, WAIT_GNT, WAIT_RDATA.
REQ-024 IDLE with MemRead or MemWrite (no Flush): assert mem_req same cycle; mem_gnt=1 -> store done, load to WAIT_RDATA; mem_gnt=0 -> WAIT_GNT.
REQ-025 WAIT_GNT: hold mem_req and all mem_* outputs stable until mem_gnt; then store -> IDLE, load -> WAIT_RDATA.
REQ-026 WAIT_RDATA: on mem_rvalid capture, extract lane, extend, return IDLE; mem_rvalid in the grant cycle SHALL be accepted (zero-wait).
REQ-027 mem_stall SHALL = memory op present AND not completing this cycle; inputs held stable by upstream while stalled.
REQ-028 While mem_stall=1 the MEM/WB register SHALL take a bubble (MemWb_RegWrite=0, other fields hold).
REQ-029 Non-memory ops SHALL pass to MEM/WB in one cycle, no stall.
REQ-030 Load data: byte offset = addr low bits; B/H/W sign-extend, BU/HU/WU zero-extend to XLEN.
REQ-031 Store: mem_be = size mask shifted by offset; mem_wdata = low bytes replicated into selected lanes.
REQ-032 Flush in IDLE SHALL suppress mem_req; Flush in WAIT_* SHALL finish the bus transaction but write a bubble and discard data.
REQ-033 Back-to-back ops: next op SHALL be issuable in the cycle after completion.

Reset
REQ-034 rstb=1 at clk edge: FSM to IDLE; mem_req, mem_we, mem_stall, all MemWb_* outputs to 0; mem_be 0.
REQ-035 Reset mid-transaction SHALL abandon it; late mem_gnt/mem_rvalid in IDLE ignored.

Configuration
REQ-036 Macro MEM_STAGE_MISALIGN_TRAP_EN defined: access not naturally aligned SHALL issue no mem_req, set MemWb_Misalign=1, MemWb_RegWrite=0, no stall.
REQ-037 Macro undefined: MemWb_Misalign tied 0; offset bits forced down to natural alignment before access.

Structure
REQ-038 Funct3 encodings, state enum, and XLEN/8 lane constants SHALL live in shared package riscv_pkg.
REQ-039 Sub-module mem_lane_align SHALL perform be/wdata generation and load extract/extend (combinational).

Verification
REQ-040 XLEN=32, SB addr 0x103 data 0xAB, gnt same cycle -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x100, no stall.
REQ-041 LB addr 0x102, gnt after 2 cycles, rvalid 1 later, rdata 0x0080FF00 -> stall 3 cycles, MemWb_MemRData=0xFFFFFF80 WU-style? no: 0xFFFFFF80, RegWrite=1.
REQ-042 LHU addr 0x102, rdata 0x80010000, zero-wait -> MemRData=0x00008001, no stall.
REQ-043 Trap build, LW addr 0x101 -> mem_req stays 0, MemWb_Misalign=1, RegWrite=0.
REQ-044 LW in WAIT_RDATA with Flush=1 -> transaction completes, MemWb_RegWrite=0; rstb asserted in WAIT_GNT -> mem_req=0 next cycle.
